run_controller: RTL and testbench

- Sequences the processor core through its fixed program set, one program per run.
- For each run it issues a single-cycle start pulse to the core's Init input, then times the run until the core raises DONE.
- It reports the program index, cycle count and timeout status to the testbench/host through a Start/Ack handshake.
- Sits between the top-level harness and the core; the core is otherwise untouched.

---
 rtl/run_ctrl_pkg.sv | 15 +
 rtl/run_controller.sv | 88 ++++++++
 tb/tb_run_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and default sizes for run_controller
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        REPORT,
        FINISHED
    } run_state_t;

    localparam int DEF_NUM_PROGS = 3;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/run_controller.sv
// rtl/run_controller.sv - sequences the core through its programs, timing each run
// and reporting results through a four-phase Start/Ack handshake.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int          NUM_PROGS  = DEF_NUM_PROGS,
    parameter int          CNT_W      = DEF_CNT_W,
    parameter int unsigned MAX_CYCLES = 50000,
    localparam int         PID_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             Start,
    input  logic             Core_done,
    output logic             Core_init,
    output logic             Busy,
    output logic             Ack,
    output logic [PID_W-1:0] Prog_id,
    output logic [CNT_W-1:0] Cycle_count,
    output logic             Timeout,
    output logic             All_done
);

    localparam logic [CNT_W-1:0] W_MAX     = CNT_W'(MAX_CYCLES);
    localparam logic [PID_W-1:0] LAST_PROG = PID_W'(NUM_PROGS - 1);

    run_state_t       r_state;
    run_state_t       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic [PID_W-1:0] r_prog;
    logic             r_timeout;

    always_comb begin
        w_next_state = r_state;
        w_count_inc  = r_count + CNT_W'(1);
        case (r_state)
            IDLE:     if (Start) w_next_state = INIT;
            INIT:     w_next_state = RUN;
            // Done takes priority over the budget on the cycle the limit would be hit.
            RUN:      if (Core_done || (w_count_inc == W_MAX)) w_next_state = REPORT;
            REPORT:   if (!Start) w_next_state = (r_prog == LAST_PROG) ? FINISHED : IDLE;
            FINISHED: w_next_state = FINISHED;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_prog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    // Results are cleared on entry to INIT so they read 0 during the pulse.
                    if (Start) begin
                        r_count   <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (Core_done) begin
                        r_timeout <= 1'b0;
                    end else begin
                        r_count   <= w_count_inc;
                        r_timeout <= (w_count_inc == W_MAX);
                    end
                end
                REPORT: begin
                    if (!Start && (r_prog != LAST_PROG)) r_prog <= r_prog + PID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign Core_init   = (r_state == INIT);
    assign Busy        = (r_state == INIT) || (r_state == RUN);
    assign Ack         = (r_state == REPORT);
    assign All_done    = (r_state == FINISHED);
    assign Prog_id     = r_prog;
    assign Cycle_count = r_count;
    assign Timeout     = r_timeout;

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - randomized scoreboard bench for run_controller
module tb_run_controller;

    localparam int NP   = 3;
    localparam int CW   = 16;
    localparam int MAXC = 45;

    logic          CLK = 1'b0;
    logic          Init = 1'b1;
    logic          Start = 1'b0;
    logic          Core_done = 1'b0;
    logic          Core_init;
    logic          Busy;
    logic          Ack;
    logic [1:0]    Prog_id;
    logic [CW-1:0] Cycle_count;
    logic          Timeout;
    logic          All_done;

    run_controller #(
        .NUM_PROGS  (NP),
        .CNT_W      (CW),
        .MAX_CYCLES (MAXC)
    ) dut (
        .CLK         (CLK),
        .Init        (Init),
        .Start       (Start),
        .Core_done   (Core_done),
        .Core_init   (Core_init),
        .Busy        (Busy),
        .Ack         (Ack),
        .Prog_id     (Prog_id),
        .Cycle_count (Cycle_count),
        .Timeout     (Timeout),
        .All_done    (All_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int prog;
        int cnt;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   init_pulses = 0;
    int   run_len = 0;
    bit   never = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Core model: after its Init pulse, DONE stays low for run_len RUN cycles, then rises and stays.
    int rem = 0;
    always @(posedge CLK) begin
        #1;
        if (Core_init) begin
            Core_done = 1'b0;
            rem = run_len;
        end else if (Busy && !never) begin
            if (rem > 0) rem--;
            else Core_done = 1'b1;
        end
    end

    // Monitor: pops the expected result on each new Ack, checks hold stability and pulse width.
    logic prev_ci = 1'b0;
    logic prev_ack = 1'b0;
    exp_t cur;
    always @(negedge CLK) begin
        if (Core_init) begin
            init_pulses++;
            chk("core_init_single_cycle", {31'd0, prev_ci}, 32'd0);
        end
        if (Ack && !prev_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                chk("prog_id", {30'd0, Prog_id}, cur.prog);
                chk("cycle_count", {16'd0, Cycle_count}, cur.cnt);
                chk("timeout", {31'd0, Timeout}, cur.to);
                chk("busy_in_report", {31'd0, Busy}, 32'd0);
            end
        end else if (Ack) begin
            chk("report_hold_count", {16'd0, Cycle_count}, cur.cnt);
            chk("report_hold_prog", {30'd0, Prog_id}, cur.prog);
        end
        prev_ci  = Core_init;
        prev_ack = Ack;
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        Init = 1'b1;
        Start = 1'b0;
        never = 1'b0;
        @(posedge CLK); #1;
        Init = 1'b0;
    endtask

    task automatic do_run(input int len, input bit nev, input int hold, input int prog);
        exp_t e;
        int   k;
        int   snap;
        e.prog = prog;
        e.cnt  = (nev || len >= MAXC) ? MAXC : len;
        e.to   = (nev || len >= MAXC) ? 1 : 0;
        exp_q.push_back(e);
        run_len = len;
        never   = nev;
        @(posedge CLK); #1;
        Start = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!Ack && k < MAXC + 20);
        if (!Ack) begin
            chk("ack_wait_expired", 32'd0, 32'd1);
        end
        snap = init_pulses;
        repeat (hold) @(negedge CLK);
        if (hold > 0) begin
            chk("report_held_with_start", {31'd0, Ack}, 32'd1);
            chk("no_reinit_while_start_high", init_pulses, snap);
        end
        @(posedge CLK); #1;
        Start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("ack_released", {31'd0, Ack}, 32'd0);
        chk("prog_after_handshake", {30'd0, Prog_id}, (prog == NP - 1) ? prog : prog + 1);
        chk("all_done_after_handshake", {31'd0, All_done}, (prog == NP - 1) ? 1 : 0);
    endtask

    task automatic run_session(input int l0, input int l1, input int l2, input int hold0);
        int snap;
        snap = init_pulses;
        do_run(l0, 1'b0, hold0, 0);
        do_run(l1, 1'b0, 0, 1);
        do_run(l2, 1'b0, 0, 2);
        chk("init_pulse_count", init_pulses - snap, 32'd3);
        snap = init_pulses;
        repeat (3) begin
            @(posedge CLK); #1; Start = 1'b1;
            repeat (2) @(posedge CLK);
            #1; Start = 1'b0;
        end
        @(negedge CLK);
        chk("finished_ignores_start", init_pulses, snap);
        chk("finished_all_done", {31'd0, All_done}, 32'd1);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_core_init", {31'd0, Core_init}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_ack", {31'd0, Ack}, 32'd0);
        chk("rst_prog_id", {30'd0, Prog_id}, 32'd0);
        chk("rst_cycle_count", {16'd0, Cycle_count}, 32'd0);
        chk("rst_timeout", {31'd0, Timeout}, 32'd0);
        chk("rst_all_done", {31'd0, All_done}, 32'd0);
        @(posedge CLK); #1;
        Init = 1'b0;

        // 40-cycle run with Start held in REPORT, then a stale-DONE run, then a pure timeout.
        run_session(40, 10, MAXC, 5);
        do_reset();
        run_session(12, 30, 5, 0);
        do_reset();
        // Done on the cycle the budget would run out, then a run whose DONE never comes.
        do_run(MAXC - 1, 1'b0, 0, 0);
        do_run(0, 1'b1, 1, 1);
        do_run(0, 1'b0, 0, 2);
        for (int s = 0; s < 4; s++) begin
            do_reset();
            run_session($urandom_range(0, MAXC + 3), $urandom_range(0, MAXC + 3),
                        $urandom_range(0, MAXC + 3), $urandom_range(0, 3));
        end

        // Reset asserted in the middle of a run.
        do_reset();
        run_len = 0;
        never   = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (Cycle_count != 4 && k < 20);
        chk("midrun_reach_count", {16'd0, Cycle_count}, 32'd4);
        @(posedge CLK); #1;
        chk("midrun_count_before_reset", {16'd0, Cycle_count}, 32'd5);
        Init  = 1'b1;
        Start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrun_rst_core_init", {31'd0, Core_init}, 32'd0);
        chk("midrun_rst_busy", {31'd0, Busy}, 32'd0);
        chk("midrun_rst_ack", {31'd0, Ack}, 32'd0);
        chk("midrun_rst_prog_id", {30'd0, Prog_id}, 32'd0);
        chk("midrun_rst_cycle_count", {16'd0, Cycle_count}, 32'd0);
        chk("midrun_rst_timeout", {31'd0, Timeout}, 32'd0);
        chk("midrun_rst_all_done", {31'd0, All_done}, 32'd0);
        @(posedge CLK); #1;
        Init = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_after_reset", {31'd0, Busy}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
